// File: rtl/cci_mpf_svc_vtp_walk_sched_pkg.sv
// Shared VTP page-walk scheduler definitions.
//   t_tlb_4kb_va_page_idx            4KB VA page index (VA bits above the page offset)
//   CCI_PT_4KB_PAGE_OFFSET_BITS      page offset width of a 4KB page
//   CCI_MPF_VTP_N_PENDING_WALKS      default pending-walk table depth
//   t_cci_mpf_vtp_walk_sched_state   scheduler FSM state
package cci_mpf_svc_vtp_walk_sched_pkg;

  localparam int unsigned CCI_MPF_VTP_VA_BITS = 48;
  localparam int unsigned CCI_PT_4KB_PAGE_OFFSET_BITS = 12;

  typedef logic [CCI_MPF_VTP_VA_BITS-CCI_PT_4KB_PAGE_OFFSET_BITS-1:0] t_tlb_4kb_va_page_idx;

  localparam int unsigned CCI_MPF_VTP_N_PENDING_WALKS = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } t_cci_mpf_vtp_walk_sched_state;

endpackage

// File: rtl/cci_mpf_svc_vtp_walk_sched_if.sv
// Signal bundle between the TLB miss / page walker side and the walk scheduler.
//   master: the scheduler (consumes misses and walker status, drives walk requests and stats)
//   slave:  the surrounding VTP logic (drives misses and walker status)
interface cci_mpf_svc_vtp_walk_sched_if
  import cci_mpf_svc_vtp_walk_sched_pkg::*;
#(
  parameter int unsigned N_PENDING    = CCI_MPF_VTP_N_PENDING_WALKS,
  parameter int unsigned VA_PAGE_BITS = $bits(t_tlb_4kb_va_page_idx)
);

  logic                        missEn;
  logic [VA_PAGE_BITS-1:0]     missVA;
  logic                        fillRdy;
  logic                        walkReqEn;
  logic [VA_PAGE_BITS-1:0]     walkReqVA;
  logic                        walkReqRdy;
  logic                        walkDone;
  logic                        walkNotPresent;
  logic                        busy;
  logic [$clog2(N_PENDING):0]  pendingCount;
  logic                        statDropDup;
  logic                        statDropFull;
  logic                        statNotPresent;

  modport master (
    input  missEn, missVA, fillRdy, walkReqRdy, walkDone, walkNotPresent,
    output walkReqEn, walkReqVA, busy, pendingCount, statDropDup, statDropFull, statNotPresent
  );

  modport slave (
    output missEn, missVA, fillRdy, walkReqRdy, walkDone, walkNotPresent,
    input  walkReqEn, walkReqVA, busy, pendingCount, statDropDup, statDropFull, statNotPresent
  );

endinterface

// File: rtl/cci_mpf_svc_vtp_walk_sched_cam.sv
// Pending-walk table storage: N_PENDING entries of valid bit + 4KB VA page index.
//   clk, reset          clock, synchronous active-high reset (clears all valid bits)
//   wr_en/wr_idx/wr_va  write a new valid entry
//   inv_en/inv_idx      invalidate an entry (write wins if both hit the same index)
//   lookup_va, match    combinational per-entry exact match against valid entries
//   head_idx, head_va   read port for the entry at the head pointer
module cci_mpf_svc_vtp_walk_sched_cam
  import cci_mpf_svc_vtp_walk_sched_pkg::*;
#(
  parameter int unsigned N_PENDING    = CCI_MPF_VTP_N_PENDING_WALKS,
  parameter int unsigned VA_PAGE_BITS = $bits(t_tlb_4kb_va_page_idx)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(N_PENDING)-1:0] wr_idx,
  input  logic [VA_PAGE_BITS-1:0]      wr_va,
  input  logic                         inv_en,
  input  logic [$clog2(N_PENDING)-1:0] inv_idx,
  input  logic [VA_PAGE_BITS-1:0]      lookup_va,
  output logic [N_PENDING-1:0]         match,
  input  logic [$clog2(N_PENDING)-1:0] head_idx,
  output logic [VA_PAGE_BITS-1:0]      head_va
);

  logic [N_PENDING-1:0]    valid_q;
  logic [VA_PAGE_BITS-1:0] va_q [N_PENDING];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (inv_en) valid_q[inv_idx] <= 1'b0;
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
    end
  end

  // VA storage needs no reset; it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (wr_en) va_q[wr_idx] <= wr_va;
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < int'(N_PENDING); i++) begin
      match[i] = valid_q[i] && (va_q[i] == lookup_va);
    end
  end

  assign head_va = va_q[head_idx];

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_PENDING); i++) begin
        for (int j = i + 1; j < int'(N_PENDING); j++) begin
          assert (!(valid_q[i] && valid_q[j] && (va_q[i] == va_q[j])))
            else $error("walk_sched_cam: entries %0d and %0d hold the same VA", i, j);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/cci_mpf_svc_vtp_walk_sched.sv
// Page-walk request scheduler between the merged TLB miss outputs and the page table walker.
// Queues unique missed 4KB pages in arrival order, drops duplicates of queued or in-flight
// walks, and issues one walk at a time, retiring it when the walker completes.
//   clk, reset   clock, synchronous active-high reset
//   bus (master) missEn/missVA/fillRdy in; walkReqEn/walkReqVA out, walkReqRdy in;
//                walkDone/walkNotPresent in; busy, pendingCount and stat* pulses out
module cci_mpf_svc_vtp_walk_sched
  import cci_mpf_svc_vtp_walk_sched_pkg::*;
#(
  parameter int unsigned N_PENDING      = CCI_MPF_VTP_N_PENDING_WALKS,
  parameter int unsigned VA_PAGE_BITS   = $bits(t_tlb_4kb_va_page_idx),
  parameter int unsigned DEBUG_MESSAGES = 0
) (
  input logic                          clk,
  input logic                          reset,
  cci_mpf_svc_vtp_walk_sched_if.master bus
);

  localparam int unsigned PtrW = $clog2(N_PENDING);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]         head_q, tail_q;
  logic [CntW-1:0]         count_q, count_d;
  logic                    busy_q;
  logic                    stat_drop_dup_q, stat_drop_full_q, stat_not_present_q;
  logic                    walk_req_en_q;
  logic [VA_PAGE_BITS-1:0] walk_req_va_q;
  t_cci_mpf_vtp_walk_sched_state state_q;

  logic [N_PENDING-1:0]    match;
  logic [VA_PAGE_BITS-1:0] head_va;
  logic                    capture, dup, full, drop_full, enq, retire;

  cci_mpf_svc_vtp_walk_sched_cam #(
    .N_PENDING    (N_PENDING),
    .VA_PAGE_BITS (VA_PAGE_BITS)
  ) u_cam (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (enq),
    .wr_idx    (tail_q),
    .wr_va     (bus.missVA),
    .inv_en    (retire),
    .inv_idx   (head_q),
    .lookup_va (bus.missVA),
    .match     (match),
    .head_idx  (head_q),
    .head_va   (head_va)
  );

  // The in-flight head stays valid until its retire edge, so a miss on the page being
  // retired this cycle matches and is dropped: the fill has already happened.
  always_comb begin
    capture   = bus.missEn && bus.fillRdy;
    dup       = capture && (|match);
    full      = (count_q == CntW'(N_PENDING));
    drop_full = capture && !(|match) && full;
    enq       = capture && !(|match) && !full;
    retire    = (state_q == StWait) && (bus.walkDone || bus.walkNotPresent);
  end

  always_comb begin
    count_d = count_q;
    case ({enq, retire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      busy_q             <= 1'b0;
      stat_drop_dup_q    <= 1'b0;
      stat_drop_full_q   <= 1'b0;
    end else begin
      if (enq)    tail_q <= tail_q + PtrW'(1);
      if (retire) head_q <= head_q + PtrW'(1);
      count_q          <= count_d;
      busy_q           <= (count_q != '0);
      stat_drop_dup_q  <= dup;
      stat_drop_full_q <= drop_full;
    end
  end

  // Issue/retire FSM with registered one-cycle walk request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      walk_req_en_q      <= 1'b0;
      walk_req_va_q      <= '0;
      stat_not_present_q <= 1'b0;
    end else begin
      walk_req_en_q      <= 1'b0;
      stat_not_present_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if ((count_q != '0) && bus.walkReqRdy) begin
            state_q       <= StWait;
            walk_req_en_q <= 1'b1;
            walk_req_va_q <= head_va;
          end
        end
        StWait: begin
          if (retire) begin
            state_q            <= StIdle;
            stat_not_present_q <= bus.walkNotPresent;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.walkReqEn      = walk_req_en_q;
  assign bus.walkReqVA      = walk_req_va_q;
  assign bus.busy           = busy_q;
  assign bus.pendingCount   = count_q;
  assign bus.statDropDup    = stat_drop_dup_q;
  assign bus.statDropFull   = stat_drop_full_q;
  assign bus.statNotPresent = stat_not_present_q;

`ifndef SYNTHESIS
  // Remembers a walk abandoned by reset so its late completion is not flagged.
  logic late_done_ok_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      late_done_ok_q <= late_done_ok_q | (state_q == StWait);
    end else if (bus.walkDone || bus.walkNotPresent) begin
      late_done_ok_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CntW'(N_PENDING))
        else $error("walk_sched: pending count %0d exceeds depth", count_q);
      if ((bus.walkDone || bus.walkNotPresent) && (state_q == StIdle) && !late_done_ok_q) begin
        $fatal(1, "walk_sched: walk completion while idle");
      end
    end
  end

  if (DEBUG_MESSAGES != 0) begin : g_debug
    always_ff @(posedge clk) begin
      if (!reset) begin
        if (walk_req_en_q) $info("walk_sched: issue VA 0x%0h", walk_req_va_q);
        if (retire) $info("walk_sched: retire VA 0x%0h notPresent=%0d", head_va,
                          bus.walkNotPresent);
        if (dup)       $info("walk_sched: drop duplicate VA 0x%0h", bus.missVA);
        if (drop_full) $info("walk_sched: drop VA 0x%0h, table full", bus.missVA);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_svc_vtp_walk_sched.sv
module tb_cci_mpf_svc_vtp_walk_sched;

  localparam int unsigned NP = 4;
  localparam int unsigned VB = 36;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cci_mpf_svc_vtp_walk_sched_if #(.N_PENDING(NP), .VA_PAGE_BITS(VB)) bus ();

  cci_mpf_svc_vtp_walk_sched #(
    .N_PENDING      (NP),
    .VA_PAGE_BITS   (VB),
    .DEBUG_MESSAGES (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_dup   = 0;
  int n_full  = 0;
  int n_np    = 0;
  int n_req   = 0;
  logic [VB-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stat-pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.statDropDup)    n_dup++;
      if (bus.statDropFull)   n_full++;
      if (bus.statNotPresent) n_np++;
      if (bus.walkReqEn) begin
        n_req++;
        if (exp_q.size() == 0) check("walk_unexpected", 64'(bus.walkReqEn), 64'd0);
        else check("walk_va_order", 64'(bus.walkReqVA), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic miss(input logic [VB-1:0] va);
    bus.missEn = 1'b1;
    bus.missVA = va;
    cyc();
    bus.missEn = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int t = 0;
    while (bus.walkReqEn !== 1'b1 && t < 40) begin
      cyc();
      t++;
    end
    check(tag, 64'(bus.walkReqEn), 64'd1);
  endtask

  // Accept n walks in turn, completing each a couple of cycles after issue.
  task automatic serve(input int n);
    for (int k = 0; k < n; k++) begin
      wait_req("serve_req_timeout");
      cyc();
      cyc();
      bus.walkDone = 1'b1;
      cyc();
      bus.walkDone = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_dup, b_full, b_req, b_np;
    reset              = 1'b1;
    bus.missEn         = 1'b0;
    bus.missVA         = '0;
    bus.fillRdy        = 1'b1;
    bus.walkReqRdy     = 1'b1;
    bus.walkDone       = 1'b0;
    bus.walkNotPresent = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;

    // Reset state
    check("rst_walkReqEn", 64'(bus.walkReqEn), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_pendingCount", 64'(bus.pendingCount), 64'd0);
    check("rst_stats", 64'({bus.statDropDup, bus.statDropFull, bus.statNotPresent}), 64'd0);

    // 1. Single miss: request two cycles later, busy clears two cycles after walkDone
    bus.missEn = 1'b1;
    bus.missVA = 36'h123;
    exp_q.push_back(36'h123);
    cyc();
    bus.missEn = 1'b0;
    check("t1_no_early_req", 64'(bus.walkReqEn), 64'd0);
    check("t1_count1", 64'(bus.pendingCount), 64'd1);
    cyc();
    check("t1_req_cycle2", 64'(bus.walkReqEn), 64'd1);
    check("t1_req_va", 64'(bus.walkReqVA), 64'h123);
    cyc();
    check("t1_req_one_cycle", 64'(bus.walkReqEn), 64'd0);
    check("t1_busy", 64'(bus.busy), 64'd1);
    repeat (7) cyc();
    bus.walkDone = 1'b1;
    cyc();
    bus.walkDone = 1'b0;
    check("t1_busy_c11", 64'(bus.busy), 64'd1);
    check("t1_count_c11", 64'(bus.pendingCount), 64'd0);
    cyc();
    check("t1_busy_c12", 64'(bus.busy), 64'd0);

    // 2. Duplicates on back-to-back cycles
    b_dup = n_dup;
    b_req = n_req;
    bus.missEn = 1'b1;
    bus.missVA = 36'h123;
    exp_q.push_back(36'h123);
    repeat (3) cyc();
    bus.missEn = 1'b0;
    cyc();
    check("t2_dup_pulses", 64'(n_dup - b_dup), 64'd2);
    check("t2_count", 64'(bus.pendingCount), 64'd1);
    cyc();
    cyc();
    bus.walkDone = 1'b1;
    cyc();
    bus.walkDone = 1'b0;
    repeat (4) cyc();
    check("t2_one_req", 64'(n_req - b_req), 64'd1);
    check("t2_count_end", 64'(bus.pendingCount), 64'd0);

    // 3. Full table, in-order issue, second round wraps the pointers
    bus.walkReqRdy = 1'b0;
    b_full = n_full;
    b_req  = n_req;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(36'h10 + 36'(i));
      miss(36'h10 + 36'(i));
    end
    cyc();
    check("t3_full_pulse", 64'(n_full - b_full), 64'd1);
    check("t3_count_full", 64'(bus.pendingCount), 64'd4);
    check("t3_no_req_unready", 64'(n_req - b_req), 64'd0);
    bus.walkReqRdy = 1'b1;
    serve(4);
    bus.walkReqRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(36'h30 + 36'(i));
      miss(36'h30 + 36'(i));
    end
    check("t3_count_round2", 64'(bus.pendingCount), 64'd4);
    bus.walkReqRdy = 1'b1;
    serve(4);
    repeat (2) cyc();
    check("t3_drained", 64'(bus.pendingCount), 64'd0);

    // 4. Retire coincident with a miss on a full table: full is judged pre-retire
    bus.walkReqRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(36'h40 + 36'(i));
      miss(36'h40 + 36'(i));
    end
    bus.walkReqRdy = 1'b1;
    wait_req("t4_issue");
    bus.walkReqRdy = 1'b0;
    cyc();
    b_full = n_full;
    bus.walkDone = 1'b1;
    bus.missEn   = 1'b1;
    bus.missVA   = 36'h20;
    cyc();
    bus.walkDone = 1'b0;
    check("t4_count_after_retire", 64'(bus.pendingCount), 64'd3);
    exp_q.push_back(36'h20);
    cyc();
    bus.missEn = 1'b0;
    check("t4_full_drop", 64'(n_full - b_full), 64'd1);
    check("t4_accept_count", 64'(bus.pendingCount), 64'd4);
    check("t4_no_full_second", 64'(bus.statDropFull), 64'd0);
    bus.walkReqRdy = 1'b1;
    serve(4);
    repeat (2) cyc();

    // 5. walkNotPresent retire, both completions together, fillRdy gating
    b_np = n_np;
    exp_q.push_back(36'h50);
    miss(36'h50);
    wait_req("t5_issue");
    cyc();
    bus.walkNotPresent = 1'b1;
    cyc();
    bus.walkNotPresent = 1'b0;
    check("t5_stat_np", 64'(bus.statNotPresent), 64'd1);
    check("t5_count", 64'(bus.pendingCount), 64'd0);
    exp_q.push_back(36'h70);
    miss(36'h70);
    wait_req("t5_issue_both");
    bus.walkDone       = 1'b1;
    bus.walkNotPresent = 1'b1;
    cyc();
    bus.walkDone       = 1'b0;
    bus.walkNotPresent = 1'b0;
    check("t5_both_stat_np", 64'(bus.statNotPresent), 64'd1);
    check("t5_both_count", 64'(bus.pendingCount), 64'd0);
    cyc();
    check("t5_np_pulses", 64'(n_np - b_np), 64'd2);
    b_dup  = n_dup;
    b_full = n_full;
    b_req  = n_req;
    bus.fillRdy = 1'b0;
    bus.missEn  = 1'b1;
    bus.missVA  = 36'h60;
    repeat (3) cyc();
    bus.missEn = 1'b0;
    repeat (3) cyc();
    bus.fillRdy = 1'b1;
    check("t5_gate_count", 64'(bus.pendingCount), 64'd0);
    check("t5_gate_busy", 64'(bus.busy), 64'd0);
    check("t5_gate_stats", 64'((n_dup - b_dup) + (n_full - b_full)), 64'd0);
    check("t5_gate_no_req", 64'(n_req - b_req), 64'd0);

    // 6. Reset mid-walk with pending entries, late walkDone afterwards
    bus.walkReqRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(36'h80 + 36'(i));
      miss(36'h80 + 36'(i));
    end
    bus.walkReqRdy = 1'b1;
    wait_req("t6_issue");
    bus.walkReqRdy = 1'b0;
    cyc();
    check("t6_count_before", 64'(bus.pendingCount), 64'd3);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) cyc();
    reset = 1'b0;
    b_req = n_req;
    bus.walkDone = 1'b1;
    cyc();
    bus.walkDone = 1'b0;
    check("t6_req", 64'(bus.walkReqEn), 64'd0);
    check("t6_count", 64'(bus.pendingCount), 64'd0);
    check("t6_stat_np", 64'(bus.statNotPresent), 64'd0);
    bus.walkReqRdy = 1'b1;
    repeat (5) cyc();
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_no_req", 64'(n_req - b_req), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cci_mpf_svc_vtp_walk_sched.md
Name: cci_mpf_svc_vtp_walk_sched

Overview:
Page-walk request scheduler between the merged TLB miss outputs and the page table walker in the VTP service.
- Holds up to N_PENDING unique missed 4KB VA page indices in arrival order.
- Drops misses that are duplicates of a queued or in-flight walk, so the walker does not repeat work.
- Issues queued walks one at a time and retires each one on walker completion.
- Replaces the "drop the miss if the walker is busy" path, so a burst of misses is queued instead of re-looked-up in the TLB.

Parameters:
N_PENDING, 4, pending-walk table depth; power of 2, minimum 2.
VA_PAGE_BITS, 36, width of a 4KB VA page index (t_tlb_4kb_va_page_idx).
DEBUG_MESSAGES, 0, nonzero enables $display on issue, retire and drop.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
missEn  in  1  TLB miss valid (both TLBs missed)
missVA  in  VA_PAGE_BITS  missed 4KB VA page index
fillRdy  in  1  TLB fill path ready; misses are ignored while low
walkReqEn  out  1  one-cycle walk request to the walker
walkReqVA  out  VA_PAGE_BITS  VA of the walk request
walkReqRdy  in  1  walker can accept a request
walkDone  in  1  walker finished and filled the TLB for the in-flight walk
walkNotPresent  in  1  walker finished; translation absent
busy  out  1  table non-empty or walk in flight
pendingCount  out  $clog2(N_PENDING)+1  valid table entries
statDropDup  out  1  pulse: miss dropped as a duplicate
statDropFull  out  1  pulse: miss dropped because the table is full
statNotPresent  out  1  pulse: walk retired via walkNotPresent

Behaviour:
- Reset: all entries invalid; head = tail = 0; count = 0; FSM in IDLE. walkReqEn, busy and all stat* outputs are 0. walkReqVA is don't-care.
- Table structure: circular buffer with head/tail pointers of $clog2(N_PENDING) bits that wrap modulo N_PENDING. Each entry holds a valid bit and a VA. count ranges 0..N_PENDING.
- Capture condition: a miss is considered in cycle N only when missEn && fillRdy.
- Duplicate check: missVA is compared in parallel (exact 4KB match) against every valid entry, including the in-flight head.
  - On a match, no enqueue; statDropDup = 1 in N+1.
- Full check: otherwise, if count == N_PENDING (value before any same-cycle retire), no enqueue; statDropFull = 1 in N+1.
- Enqueue: otherwise, write the entry at tail, tail++, count++ at the N/N+1 edge.
- Duplicate takes priority over full: when both apply, only statDropDup pulses.
- FSM states IDLE and WAIT:
  - IDLE → WAIT when count > 0 && walkReqRdy (registered values). Register walkReqEn = 1 and walkReqVA = head VA for exactly one cycle.
  - WAIT: on walkDone || walkNotPresent, invalidate head, head++, count--, statNotPresent = walkNotPresent (registered), go to IDLE.
  - WAIT ignores walkReqRdy.
- Latency: a miss accepted in cycle N into an empty table with the FSM in IDLE produces walkReqEn in cycle N+2. After a retire in cycle M, the next walkReqEn is no earlier than M+2.
- Same-cycle retire and enqueue: both apply; count is unchanged.
- Same-cycle retire and duplicate of the retiring head: treated as a duplicate and dropped, because the fill is already done.
- walkDone or walkNotPresent in IDLE, or both asserted together: walkDone/walkNotPresent in IDLE are ignored. Both asserted together retire once with statNotPresent = 1. A simulation assertion fires $fatal on a done/notPresent pulse while in IDLE.
- busy = (count != 0), registered.
- Reset mid-walk: the table is flushed and the FSM returns to IDLE. A late walkDone arriving after reset is ignored per the IDLE rule.
- Assertions (simulation only, inactive during reset): count never exceeds N_PENDING; no two valid entries hold the same VA.

Decomposition:
- Use t_tlb_4kb_va_page_idx and CCI_PT_4KB_PAGE_OFFSET_BITS from the existing VTP shared header (cci_mpf_shim_vtp.vh).
- Add to that header: the FSM state enum t_cci_mpf_vtp_walk_sched_state (IDLE, WAIT) and the default CCI_MPF_VTP_N_PENDING_WALKS = 4.
- One sub-module: cci_mpf_svc_vtp_walk_sched_cam.
  - Holds the N_PENDING valid+VA array with write and invalidate ports.
  - Outputs a combinational match vector and the head VA.
- The top level holds the pointers, count, FSM and stat registers.

Test Plan:
1. Single miss: missEn=1, missVA=0x123, fillRdy=1, walkReqRdy=1 at cycle 0 → walkReqEn=1 with walkReqVA=0x123 at cycle 2; walkDone at cycle 10 → busy=0 at cycle 12, pendingCount=0.
2. Duplicates: 0x123 three times on back-to-back cycles → one entry, statDropDup pulses twice, exactly one walkReqEn.
3. Full: 5 unique VAs 0x10..0x14 with walkReqRdy=0 → 0x14 dropped with statDropFull=1, pendingCount=4; walkReqRdy=1 → issue order 0x10, 0x11, 0x12, 0x13, covering pointer wrap after a second fill round.
4. Retire+enqueue: table full, walkDone coincident with a new VA 0x20 → 0x20 dropped (full is checked pre-retire), pendingCount=3. Repeat one cycle later → 0x20 accepted.
5. notPresent and fillRdy gating: walkNotPresent in WAIT → statNotPresent=1, head retired. missEn with fillRdy=0 → no enqueue, no stat pulse.
6. Reset mid-walk: reset during WAIT with 3 pending entries, then walkDone after reset → walkReqEn=0, pendingCount=0, no assertion failure.
